// File: rtl/irq_ctrl_pkg.sv
// Shared types and defaults for the prioritised interrupt controller.
// Holds the FSM state encoding and the vector arithmetic helper.
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam int VEC_BASE_DEF   = 2;
  localparam int VEC_STRIDE_DEF = 2;

  // Vector wraps modulo 256 by truncation.
  function automatic logic [7:0] calc_vector(input int base, input int stride, input int id);
    return 8'(base + id * stride);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side irq/ack handshake bundle between the controller and the CPU core.
// The slave modport is the controller; the master modport is the CPU.
interface irq_ctrl_if;
  logic       ack;
  logic       eoi;
  logic       ei;
  logic       di;
  logic       irq;
  logic [7:0] vector;
  logic       ie;
  logic       in_service;

  modport master (
    output ack, eoi, ei, di,
    input  irq, vector, ie, in_service
  );

  modport slave (
    input  ack, eoi, ei, di,
    output irq, vector, ie, in_service
  );
endinterface

// File: rtl/irq_ctrl_btn_debounce.sv
// Per-button input path: 2-flop synchroniser, tick-sampled debounce and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic src_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic deb_q, deb_d;
  logic press_q, press_d;

  always_comb begin
    sync1_d = ~src_n;
    sync2_d = sync1_q;
    prev_d  = prev_q;
    deb_d   = deb_q;
    // Level must match on two consecutive ticks before deb follows it.
    if (tick) begin
      prev_d = sync2_q;
      if (sync2_q == prev_q) deb_d = sync2_q;
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      deb_q   <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: debounced button presses become pending
// requests, granted one at a time to the CPU through an irq/ack/eoi handshake.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | waiting for ie and an unmasked pending request
//   ST_REQ     | irq raised, id/vector frozen until ack or withdrawal
//   ST_SERVICE | handler running, waiting for eoi
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DEB_BITS   = 16,
  parameter int VEC_BASE   = VEC_BASE_DEF,
  parameter int VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_n,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  output logic [N_SRC-1:0] mask,
  output logic [N_SRC-1:0] pending,
  irq_ctrl_if.slave        cpu
);

  localparam int ID_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [DEB_BITS-1:0] prescaler_q, prescaler_d;
  logic                tick;
  logic [N_SRC-1:0]    press;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [7:0]       vector_q, vector_d;
  logic             irq_q, irq_d;
  logic             in_service_q, in_service_d;
  logic             ie_q, ie_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] pending_q, pending_d;

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] pend_clr;
  logic [ID_W-1:0]  grant_id;

  assign prescaler_d = prescaler_q + {{(DEB_BITS-1){1'b0}}, 1'b1};
  assign tick        = &prescaler_q;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    btn_debounce u_deb (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .src_n (src_n[g]),
      .press (press[g])
    );
  end

  assign req = pending_q & mask_q;

  // Lowest set index wins.
  always_comb begin
    grant_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) grant_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    vector_d     = vector_q;
    irq_d        = irq_q;
    in_service_d = in_service_q;
    ie_d         = ie_q;
    mask_d       = mask_q;
    pend_clr     = '0;

    if (mask_we) mask_d = mask_wdata;
    if (cpu.ei)  ie_d = 1'b1;
    if (cpu.di)  ie_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ie_q && (|req)) begin
          id_d     = grant_id;
          vector_d = calc_vector(VEC_BASE, VEC_STRIDE, int'(grant_id));
          irq_d    = 1'b1;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack takes precedence over a same-cycle withdrawal.
        if (cpu.ack) begin
          pend_clr[id_q] = 1'b1;
          irq_d          = 1'b0;
          in_service_d   = 1'b1;
          ie_d           = 1'b0;
          state_d        = ST_SERVICE;
        end else if (cpu.di || !mask_q[id_q]) begin
          irq_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (cpu.eoi) begin
          in_service_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        irq_d        = 1'b0;
        in_service_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase

    // A press coinciding with its own ack re-arms the request.
    pending_d = (pending_q & ~pend_clr) | press;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler_q  <= '0;
      state_q      <= ST_IDLE;
      id_q         <= '0;
      vector_q     <= 8'(VEC_BASE);
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
      ie_q         <= 1'b0;
      mask_q       <= '1;
      pending_q    <= '0;
    end else begin
      prescaler_q  <= prescaler_d;
      state_q      <= state_d;
      id_q         <= id_d;
      vector_q     <= vector_d;
      irq_q        <= irq_d;
      in_service_q <= in_service_d;
      ie_q         <= ie_d;
      mask_q       <= mask_d;
      pending_q    <= pending_d;
    end
  end

  assign cpu.irq        = irq_q;
  assign cpu.vector     = vector_q;
  assign cpu.ie         = ie_q;
  assign cpu.in_service = in_service_q;
  assign mask           = mask_q;
  assign pending        = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected vectors are queued when a press is
// driven and popped when irq rises.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src_n;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] mask;
  logic [3:0] pending;

  irq_ctrl_if cpu_if ();

  irq_ctrl #(
    .N_SRC      (4),
    .DEB_BITS   (2),
    .VEC_BASE   (2),
    .VEC_STRIDE (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_n      (src_n),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pending    (pending),
    .cpu        (cpu_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack(); cpu_if.ack = 1'b1; cycle(); cpu_if.ack = 1'b0; endtask
  task automatic pulse_eoi(); cpu_if.eoi = 1'b1; cycle(); cpu_if.eoi = 1'b0; endtask
  task automatic pulse_ei();  cpu_if.ei  = 1'b1; cycle(); cpu_if.ei  = 1'b0; endtask
  task automatic pulse_di();  cpu_if.di  = 1'b1; cycle(); cpu_if.di  = 1'b0; endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m; cycle(); mask_we = 1'b0;
  endtask

  task automatic release_all();
    src_n = 4'hf;
    cycle(14);
  endtask

  // Waits for irq within a cycle budget, then pops and checks the vector.
  task automatic wait_irq(input string tag, input int budget);
    int n = 0;
    logic [7:0] e;
    while (!cpu_if.irq && n < budget) begin
      cycle();
      n++;
    end
    if (exp_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      if (!cpu_if.irq) check_val({tag, "_timeout"}, 0, 1);
      else             check_val(tag, {24'd0, cpu_if.vector}, {24'd0, e});
    end
  endtask

  initial begin
    rst = 1'b1; src_n = 4'hf; mask_we = 1'b0; mask_wdata = 4'h0;
    cpu_if.ack = 1'b0; cpu_if.eoi = 1'b0; cpu_if.ei = 1'b0; cpu_if.di = 1'b0;
    cycle(3);
    rst = 1'b0;
    check_val("rst_irq",  {31'd0, cpu_if.irq}, 0);
    check_val("rst_vec",  {24'd0, cpu_if.vector}, 2);
    check_val("rst_ie",   {31'd0, cpu_if.ie}, 0);
    check_val("rst_mask", {28'd0, mask}, 4'hf);
    check_val("rst_pend", {28'd0, pending}, 0);
    check_val("rst_isr",  {31'd0, cpu_if.in_service}, 0);

    // Single press on source 1.
    pulse_ei();
    src_n = 4'b1101;
    exp_q.push_back(8'd4);
    wait_irq("p1_vec", 20);
    check_val("p1_pend", {28'd0, pending}, 4'b0010);
    pulse_ack();
    check_val("p1_ack_irq",  {31'd0, cpu_if.irq}, 0);
    check_val("p1_ack_isr",  {31'd0, cpu_if.in_service}, 1);
    check_val("p1_ack_ie",   {31'd0, cpu_if.ie}, 0);
    check_val("p1_ack_pend", {28'd0, pending}, 0);
    pulse_eoi();
    check_val("p1_eoi_isr",  {31'd0, cpu_if.in_service}, 0);
    release_all();

    // One-cycle glitch must be rejected.
    pulse_ei();
    src_n = 4'b1110;
    cycle();
    src_n = 4'hf;
    cycle(16);
    check_val("gl_pend", {28'd0, pending}, 0);
    check_val("gl_irq",  {31'd0, cpu_if.irq}, 0);

    // Sources 3 and 1 together: 1 first, then 3 after re-enable.
    src_n = 4'b0101;
    exp_q.push_back(8'd4);
    wait_irq("p31_first", 20);
    pulse_ack();
    pulse_eoi();
    check_val("p31_pend", {28'd0, pending}, 4'b1000);
    src_n = 4'hf;
    pulse_ei();
    exp_q.push_back(8'd8);
    wait_irq("p31_second", 3);
    pulse_ack();
    pulse_eoi();
    release_all();

    // Press with ie=0 stays pending; ei raises irq one cycle later.
    src_n = 4'b1110;
    cycle(14);
    check_val("ie0_pend", {28'd0, pending}, 4'b0001);
    check_val("ie0_irq",  {31'd0, cpu_if.irq}, 0);
    src_n = 4'hf;
    pulse_ei();
    check_val("ei_lat0", {31'd0, cpu_if.irq}, 0);
    cycle();
    exp_q.push_back(8'd2);
    wait_irq("ei_lat1", 0);
    pulse_ack();
    pulse_eoi();
    cycle(14);

    // Masked source 0, unmask, then withdraw with di.
    write_mask(4'b1110);
    pulse_ei();
    src_n = 4'b1110;
    cycle(14);
    check_val("msk_pend", {28'd0, pending}, 4'b0001);
    check_val("msk_irq",  {31'd0, cpu_if.irq}, 0);
    src_n = 4'hf;
    write_mask(4'b1111);
    exp_q.push_back(8'd2);
    wait_irq("unmask", 3);
    pulse_di();
    check_val("di_irq",  {31'd0, cpu_if.irq}, 0);
    check_val("di_pend", {28'd0, pending}, 4'b0001);
    cycle(14);

    // Reset in REQ.
    write_mask(4'b1011);
    pulse_ei();
    exp_q.push_back(8'd2);
    wait_irq("pre_rst", 3);
    rst = 1'b1;
    cycle();
    check_val("mid_rst_irq",  {31'd0, cpu_if.irq}, 0);
    check_val("mid_rst_pend", {28'd0, pending}, 0);
    check_val("mid_rst_ie",   {31'd0, cpu_if.ie}, 0);
    check_val("mid_rst_mask", {28'd0, mask}, 4'hf);
    rst = 1'b0;
    cycle();

    // ack and di together in REQ: ack wins.
    pulse_ei();
    src_n = 4'b1011;
    exp_q.push_back(8'd6);
    wait_irq("p2_vec", 20);
    cpu_if.ack = 1'b1; cpu_if.di = 1'b1;
    cycle();
    cpu_if.ack = 1'b0; cpu_if.di = 1'b0;
    check_val("ackdi_isr",  {31'd0, cpu_if.in_service}, 1);
    check_val("ackdi_irq",  {31'd0, cpu_if.irq}, 0);
    check_val("ackdi_pend", {28'd0, pending}, 0);
    pulse_eoi();
    check_val("ackdi_eoi",  {31'd0, cpu_if.in_service}, 0);
    check_val("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Prioritised interrupt controller for the 8-bit button-driven CPU. It debounces the raw active-low push-button lines and latches press events as pending requests. It arbitrates among unmasked pending requests by fixed priority and hands the CPU a single request with an 8-bit jump vector through an irq/ack handshake. It then tracks the in-service request until end-of-interrupt, replacing the CPU's inline button-to-PC logic.

## Interface
Parameters:
- N_SRC, 4, number of interrupt sources; index 0 is highest priority.
- DEB_BITS, 16, debounce prescaler width; one sample tick every 2^DEB_BITS clocks.
- VEC_BASE, 2, vector of source 0.
- VEC_STRIDE, 2, vector spacing between consecutive sources.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- src_n  in  N_SRC  raw button lines, active-low, asynchronous.
- mask_we  in  1  write strobe for mask.
- mask_wdata  in  N_SRC  new mask; 1 = enabled.
- ei  in  1  one-cycle pulse, set ie.
- di  in  1  one-cycle pulse, clear ie.
- ack  in  1  CPU accepts current irq; one-cycle pulse.
- eoi  in  1  CPU finished handler; one-cycle pulse.
- irq  out  1  request to CPU.
- vector  out  8  jump target for the granted source.
- ie  out  1  global interrupt enable.
- mask  out  N_SRC  current mask.
- pending  out  N_SRC  latched press events.
- in_service  out  1  handler active.

## Operation
- Input path per source: 2-flop synchroniser on ~src_n (active-high level s), then debouncer.
- Debouncer: a free-running DEB_BITS prescaler drives it; tick = prescaler all-ones. On each tick, sample s into prev. The debounced level deb takes s when s == prev. A press is deb 0→1, registered as a one-cycle pulse.
- pending[i]: set by a press on source i; cleared by ack for the granted id.
  - A press on the granted source in the same cycle as its ack leaves pending[i]=1.
- mask: reset to all ones; loaded from mask_wdata on mask_we. Mask does not clear pending.
- ie: reset 0; ei sets it; di clears it; ack clears it. ei and di in the same cycle: di wins.
- FSM states IDLE, REQ, SERVICE:
  - IDLE: if ie && |(pending & mask), grant id = lowest set index. Set irq=1 and vector = (VEC_BASE + id*VEC_STRIDE) mod 256, then go to REQ.
  - REQ: id and vector frozen; later-arriving higher-priority requests do not pre-empt.
    - ack: clear pending[id], irq=0, go to SERVICE.
    - di (or mask bit of id cleared) without ack: irq=0, go to IDLE, pending kept.
    - ack and di in the same cycle: ack wins.
  - SERVICE: in_service=1; eoi returns to IDLE. ie stays 0 until an explicit ei.
- ack outside REQ and eoi outside SERVICE are ignored.
- Reset values: irq 0, vector VEC_BASE, ie 0, mask all ones, pending 0, in_service 0, state IDLE, prescaler 0, synchronisers/deb/prev 0.
  - Reset applies mid-handshake: any outstanding irq drops on the next edge.

## Timing
- All outputs are registered.
- Press-to-pending: 2 sync cycles, plus up to two ticks for debounce, plus 1 cycle for the edge pulse, plus 1 cycle for pending.
- pending (with ie and mask valid) to irq: 1 cycle.
- ack to irq low and in_service high: 1 cycle, same edge. ack to ie low: 1 cycle.
- eoi to in_service low: 1 cycle. A new irq can rise on the cycle after in_service falls.
- Throughput: at most one grant per REQ→SERVICE→IDLE round trip (minimum 3 cycles with ei).

## Structure
- Shared package holds the FSM state encoding (IDLE/REQ/SERVICE, 2 bits) and the default vector constants VEC_BASE/VEC_STRIDE.
- One sub-module, btn_debounce: synchroniser, sample/prev compare and press pulse for a single source. It is instantiated N_SRC times and shares the tick from the parent's prescaler.
- Priority encoder, pending, mask, ie and FSM live in irq_ctrl.

## Test plan
Bench uses DEB_BITS=2, VEC_BASE=2, VEC_STRIDE=2, N_SRC=4.
- Reset then ei; hold src_n=4'b1101 stable for 12 cycles → pending=0010, irq=1, vector=4. Pulse ack → irq=0, in_service=1, ie=0, pending=0000. Pulse eoi → in_service=0.
- src_n glitch low for 1 cycle (shorter than a tick) → pending stays 0000, irq stays 0.
- Sources 3 and 1 pressed together with ie=1 → vector=4 (source 1). After ack, eoi, ei → second irq with vector=8.
- ie=0, press source 0 → pending=0001, irq=0. Pulse ei → irq rises 1 cycle later, vector=2.
- mask_wdata=1110 with source 0 pending → no irq. Set mask to 1111 → irq, vector=2. In REQ, pulse di → irq=0, pending=0001 retained.
- Assert rst while in REQ → next cycle irq=0, pending=0000, ie=0, mask=1111. ack and di in the same cycle in REQ → SERVICE entered.
